// File: rtl/el2_dccm_sram_sink_if.sv
// -----------------------------------------------------------------------------
// el2_dccm_sram_sink_if
//   Bundle of the DCCM SRAM export signals plus the ECC error-injection
//   handshake.
//   master : the side that drives accesses and injection requests
//            (core memory wrapper or testbench).
//   slave  : the SRAM sink that stores words and answers the requests.
//
//   dccm_clken        per-bank access enable
//   dccm_wren_bank    per-bank write(1)/read(0), qualified by clken
//   dccm_addr_bank    per-bank word address, bank b at [b*BANK_ADDR_W +: BANK_ADDR_W]
//   dccm_wr_data_bank per-bank 32-bit write data
//   dccm_wr_ecc_bank  per-bank 7-bit write ECC
//   dccm_bank_dout    per-bank registered read data
//   dccm_bank_ecc     per-bank registered read ECC
//   inj_req           level request, held until inj_ack
//   inj_bank/addr/bit target of the single-bit flip (bit index in {ecc,data})
//   inj_ack/inj_err   one-cycle completion pulse and its abort flag
// -----------------------------------------------------------------------------
interface el2_dccm_sram_sink_if #(
   parameter int DCCM_NUM_BANKS = 4,
   parameter int BANK_ADDR_W    = 11
);
   logic [DCCM_NUM_BANKS-1:0]             dccm_clken;
   logic [DCCM_NUM_BANKS-1:0]             dccm_wren_bank;
   logic [DCCM_NUM_BANKS*BANK_ADDR_W-1:0] dccm_addr_bank;
   logic [DCCM_NUM_BANKS*32-1:0]          dccm_wr_data_bank;
   logic [DCCM_NUM_BANKS*7-1:0]           dccm_wr_ecc_bank;
   logic [DCCM_NUM_BANKS*32-1:0]          dccm_bank_dout;
   logic [DCCM_NUM_BANKS*7-1:0]           dccm_bank_ecc;

   logic                                  inj_req;
   logic [1:0]                            inj_bank;
   logic [BANK_ADDR_W-1:0]                inj_addr;
   logic [5:0]                            inj_bit;
   logic                                  inj_ack;
   logic                                  inj_err;

   modport master (
      output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
      output inj_req, inj_bank, inj_addr, inj_bit,
      input  dccm_bank_dout, dccm_bank_ecc, inj_ack, inj_err
   );

   modport slave (
      input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
      input  inj_req, inj_bank, inj_addr, inj_bit,
      output dccm_bank_dout, dccm_bank_ecc, inj_ack, inj_err
   );
endinterface

// File: rtl/el2_dccm_sram_sink.sv
// -----------------------------------------------------------------------------
// el2_dccm_sram_sink
//   Behavioural stand-in for the per-bank DCCM SRAM macros. Each bank is an
//   independent BANK_DEPTH x 39-bit array ({ecc[6:0], data[31:0]}) with a
//   registered read port of one-cycle latency. A small injector flips one
//   stored bit, but only on an edge where the target bank is not accessed.
//
//   clk    core clock
//   rst_l  asynchronous active-low reset (clears read registers and the
//          injector; array contents are left alone)
//   dccm   el2_dccm_sram_sink_if.slave: access bus and injection handshake
// -----------------------------------------------------------------------------
module el2_dccm_sram_sink #(
   parameter int DCCM_NUM_BANKS = 4,
   parameter int BANK_DEPTH     = 2048,
   parameter int BANK_ADDR_W    = 11,
   parameter int INJ_TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst_l,
   el2_dccm_sram_sink_if.slave       dccm
);

   localparam int WORD_W  = 39;
   localparam int SEL_W   = (DCCM_NUM_BANKS > 1) ? $clog2(DCCM_NUM_BANKS) : 1;
   localparam int CNT_W   = (INJ_TIMEOUT > 0) ? $clog2(INJ_TIMEOUT + 1) : 1;
   localparam int MAX_BIT = WORD_W - 1;

   typedef enum logic [1:0] {
      INJ_IDLE,
      INJ_WAIT,
      INJ_ACK
   } inj_state_e;

   logic [WORD_W-1:0]      mem     [DCCM_NUM_BANKS][BANK_DEPTH];
   logic [BANK_ADDR_W-1:0] addr    [DCCM_NUM_BANKS];
   logic [WORD_W-1:0]      wr_word [DCCM_NUM_BANKS];
   logic [WORD_W-1:0]      rd_d    [DCCM_NUM_BANKS];
   logic [WORD_W-1:0]      rd_q    [DCCM_NUM_BANKS];

   inj_state_e             state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [SEL_W-1:0]       tgt_bank_q;
   logic [BANK_ADDR_W-1:0] tgt_addr_q;
   logic [5:0]             tgt_bit_q;
   logic                   ack_q;
   logic                   err_q;

   logic                   req_bad;
   logic                   inj_fire;
   logic [WORD_W-1:0]      flip_mask;

   // ---------------------------------------------------------------------------
   // Unpack the flat per-bank buses and compute the next read-register values.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
         // NOTE: every variable gets a value before any condition so no latch is inferred.
         addr[b]    = dccm.dccm_addr_bank[b*BANK_ADDR_W +: BANK_ADDR_W];
         wr_word[b] = {dccm.dccm_wr_ecc_bank[b*7 +: 7], dccm.dccm_wr_data_bank[b*32 +: 32]};
         rd_d[b]    = rd_q[b];
         // Writes never update the read register: there is no write-through.
         if (dccm.dccm_clken[b] && !dccm.dccm_wren_bank[b]) begin
            rd_d[b] = mem[b][addr[b]];
         end
      end
   end

   // A request is rejected up front when it names a bank or bit that does not exist.
   assign req_bad   = ({30'd0, dccm.inj_bank} >= 32'(DCCM_NUM_BANKS)) || (dccm.inj_bit > 6'(MAX_BIT));

   // The flip only happens on an edge where the core leaves the target bank alone.
   assign inj_fire  = (state_q == INJ_WAIT) && !dccm.dccm_clken[tgt_bank_q];
   assign flip_mask = {{(WORD_W-1){1'b0}}, 1'b1} << tgt_bit_q;

   // ---------------------------------------------------------------------------
   // Storage arrays.
   // ---------------------------------------------------------------------------
   // NOTE: the SRAM array is deliberately not reset, like the foundry macro it
   // replaces; a reset here would also prevent block-RAM inference on FPGA.
   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk) begin
      for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
         if (dccm.dccm_clken[b] && dccm.dccm_wren_bank[b]) begin
            mem[b][addr[b]] <= wr_word[b];
         end
      end
      // inj_fire implies the target bank has clken low, so this never races a core write.
      if (inj_fire) begin
         mem[tgt_bank_q][tgt_addr_q] <= mem[tgt_bank_q][tgt_addr_q] ^ flip_mask;
      end
   end

   // Read registers: hold until the next read of the same bank.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int b = 0; b < DCCM_NUM_BANKS; b++) rd_q[b] <= '0;
      end else begin
         for (int b = 0; b < DCCM_NUM_BANKS; b++) rd_q[b] <= rd_d[b];
      end
   end

   always_comb begin
      dccm.dccm_bank_dout = '0;
      dccm.dccm_bank_ecc  = '0;
      for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
         dccm.dccm_bank_dout[b*32 +: 32] = rd_q[b][31:0];
         dccm.dccm_bank_ecc[b*7 +: 7]    = rd_q[b][38:32];
      end
   end

   // ---------------------------------------------------------------------------
   // Injection FSM. Target fields are captured once in IDLE and stay frozen
   // until the request completes. ack/err are registered and pulse for the
   // single cycle spent in ACK.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= INJ_IDLE;
         cnt_q      <= '0;
         tgt_bank_q <= '0;
         tgt_addr_q <= '0;
         tgt_bit_q  <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            INJ_IDLE: begin
               if (dccm.inj_req) begin
                  tgt_bank_q <= SEL_W'(dccm.inj_bank);
                  tgt_addr_q <= dccm.inj_addr;
                  tgt_bit_q  <= dccm.inj_bit;
                  if (req_bad) begin
                     state_q <= INJ_ACK;
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= INJ_WAIT;
                  end
               end
            end
            INJ_WAIT: begin
               // An idle edge wins even on the last allowed busy cycle.
               if (!dccm.dccm_clken[tgt_bank_q]) begin
                  state_q <= INJ_ACK;
                  ack_q   <= 1'b1;
               end else if (cnt_q == CNT_W'(INJ_TIMEOUT)) begin
                  state_q <= INJ_ACK;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            INJ_ACK: state_q <= INJ_IDLE;
            default: state_q <= INJ_IDLE;
         endcase
      end
   end

   assign dccm.inj_ack = ack_q;
   assign dccm.inj_err = err_q;

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
// -----------------------------------------------------------------------------
// tb_el2_dccm_sram_sink
//   Two sinks: a 4-bank default instance checked against a word-level memory
//   model, and a 2-bank, INJ_TIMEOUT=8 instance for the abort and reset cases.
// -----------------------------------------------------------------------------
module tb_el2_dccm_sram_sink;

   localparam int NB      = 4;
   localparam int AW      = 11;
   localparam int S_NB    = 2;
   localparam int S_AW    = 4;
   localparam int S_TMO   = 8;

   logic clk = 1'b0;
   logic rst_l;
   logic rst2_l;

   always #5 clk = ~clk;

   el2_dccm_sram_sink_if #(.DCCM_NUM_BANKS(NB),   .BANK_ADDR_W(AW))   bus  ();
   el2_dccm_sram_sink_if #(.DCCM_NUM_BANKS(S_NB), .BANK_ADDR_W(S_AW)) bus2 ();

   el2_dccm_sram_sink #(
      .DCCM_NUM_BANKS(NB), .BANK_DEPTH(2048), .BANK_ADDR_W(AW), .INJ_TIMEOUT(255)
   ) u_dut (
      .clk   (clk),
      .rst_l (rst_l),
      .dccm  (bus.slave)
   );

   el2_dccm_sram_sink #(
      .DCCM_NUM_BANKS(S_NB), .BANK_DEPTH(16), .BANK_ADDR_W(S_AW), .INJ_TIMEOUT(S_TMO)
   ) u_small (
      .clk   (clk),
      .rst_l (rst2_l),
      .dccm  (bus2.slave)
   );

   // Reference model of the 4-bank instance: array contents and the word each
   // bank's read register should be showing.
   logic [38:0]    model  [NB][2048];
   logic [38:0]    exp_rd [NB];

   logic [NB-1:0]  d_en;
   logic [NB-1:0]  d_we;
   logic [AW-1:0]  d_addr [NB];
   logic [38:0]    d_word [NB];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_drive();
      d_en = '0;
      d_we = '0;
      for (int b = 0; b < NB; b++) begin
         d_addr[b] = '0;
         d_word[b] = '0;
      end
   endtask

   // One clock: apply d_* to the big sink, update the model at the edge,
   // compare every bank's read register half a cycle later.
   task automatic tick();
      bus.dccm_clken     = d_en;
      bus.dccm_wren_bank = d_we;
      for (int b = 0; b < NB; b++) begin
         bus.dccm_addr_bank[b*AW +: AW]   = d_addr[b];
         bus.dccm_wr_data_bank[b*32 +: 32] = d_word[b][31:0];
         bus.dccm_wr_ecc_bank[b*7 +: 7]    = d_word[b][38:32];
      end
      @(posedge clk);
      for (int b = 0; b < NB; b++) begin
         if (d_en[b]) begin
            if (d_we[b]) model[b][d_addr[b]] = d_word[b];
            else         exp_rd[b] = model[b][d_addr[b]];
         end
      end
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
         check($sformatf("rd_b%0d", b),
               {25'd0, bus.dccm_bank_ecc[b*7 +: 7], bus.dccm_bank_dout[b*32 +: 32]},
               {25'd0, exp_rd[b]});
      end
      idle_drive();
   endtask

   task automatic rw(input int bank, input logic we, input int addr, input logic [38:0] word);
      d_en[bank]   = 1'b1;
      d_we[bank]   = we;
      d_addr[bank] = AW'(addr);
      d_word[bank] = word;
   endtask

   // Injection on the big sink. The target bank is read for the first n_busy
   // clocks (starting with the request clock). The flip lands on the first
   // idle edge after the request edge, so the ack is seen after clock
   // max(1, n_busy); a bad bit index is acked after the request clock itself.
   task automatic inject(input string tag, input int bank, input int addr, input int bitn,
                         input int n_busy, input int busy_addr);
      int   exp_edge;
      logic exp_err;
      int   got_edge;
      logic got_err;
      exp_err  = (bitn > 38);
      exp_edge = exp_err ? 0 : ((n_busy < 1) ? 1 : n_busy);
      got_edge = -1;
      got_err  = 1'b0;
      bus.inj_req  = 1'b1;
      bus.inj_bank = 2'(bank);
      bus.inj_addr = AW'(addr);
      bus.inj_bit  = 6'(bitn);
      for (int t = 0; t < 40 && got_edge < 0; t++) begin
         if (t < n_busy) rw(bank, 1'b0, busy_addr, '0);
         tick();
         if (bus.inj_ack) begin
            got_edge    = t;
            got_err     = bus.inj_err;
            bus.inj_req = 1'b0;
         end else if (t == 0) begin
            // Target must already be captured; scrambling the inputs has no effect.
            bus.inj_bank = 2'($urandom);
            bus.inj_addr = AW'($urandom);
            bus.inj_bit  = 6'($urandom);
         end
      end
      bus.inj_req = 1'b0;
      check({tag, "_ack_cycle"}, 64'(got_edge), 64'(exp_edge));
      check({tag, "_err"}, {63'd0, got_err}, {63'd0, exp_err});
      tick();
      check({tag, "_ack_pulse"}, {63'd0, bus.inj_ack}, 64'd0);
      if (!exp_err && got_edge >= 0) model[bank][addr] = model[bank][addr] ^ (39'd1 << bitn);
   endtask

   task automatic s_idle();
      bus2.dccm_clken        = '0;
      bus2.dccm_wren_bank    = '0;
      bus2.dccm_addr_bank    = '0;
      bus2.dccm_wr_data_bank = '0;
      bus2.dccm_wr_ecc_bank  = '0;
   endtask

   initial begin
      logic [38:0] saved;
      int          got_edge;
      logic        got_err;

      rst_l  = 1'b0;
      rst2_l = 1'b0;
      bus.inj_req   = 1'b0;
      bus.inj_bank  = '0;
      bus.inj_addr  = '0;
      bus.inj_bit   = '0;
      bus2.inj_req  = 1'b0;
      bus2.inj_bank = '0;
      bus2.inj_addr = '0;
      bus2.inj_bit  = '0;
      s_idle();
      idle_drive();
      for (int b = 0; b < NB; b++) exp_rd[b] = '0;
      bus.dccm_clken = '0;
      bus.dccm_wren_bank = '0;
      bus.dccm_addr_bank = '0;
      bus.dccm_wr_data_bank = '0;
      bus.dccm_wr_ecc_bank = '0;

      @(negedge clk);
      @(negedge clk);
      check("rst_dout", {32'd0, bus.dccm_bank_dout[127:96]} | 64'(bus.dccm_bank_dout[95:0]), 64'd0);
      check("rst_ecc", 64'(bus.dccm_bank_ecc), 64'd0);
      check("rst_ack", {62'd0, bus.inj_ack, bus.inj_err}, 64'd0);
      rst_l  = 1'b1;
      rst2_l = 1'b1;
      tick();

      // Preload words 0..15 of every bank.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < NB; b++) rw(b, 1'b1, a, 39'({$urandom, $urandom}));
         tick();
      end

      // Write then read back bank 2, word 0x10.
      rw(2, 1'b1, 'h10, {7'h55, 32'hDEADBEEF});
      tick();
      rw(2, 1'b0, 'h10, '0);
      tick();
      check("b2_rdback", {25'd0, bus.dccm_bank_ecc[20:14], bus.dccm_bank_dout[95:64]},
            {25'd0, 7'h55, 32'hDEADBEEF});

      // Same-clock write bank 0 / read bank 1, banks 2-3 idle.
      rw(0, 1'b0, 3, '0);
      tick();
      rw(0, 1'b1, 3, 39'h12_3456_789A);
      rw(1, 1'b0, 4, '0);
      tick();

      // Flip bit 3 of a zero word in an idle bank.
      rw(1, 1'b1, 5, '0);
      tick();
      inject("inj_idle", 1, 5, 3, 0, 0);
      rw(1, 1'b0, 5, '0);
      tick();
      check("inj_idle_word", {25'd0, bus.dccm_bank_ecc[13:7], bus.dccm_bank_dout[63:32]},
            {25'd0, 7'h00, 32'h0000_0008});

      // Flip ECC bit 3 (index 35) while bank 3 is read for 10 clocks.
      rw(3, 1'b1, 7, '0);
      tick();
      inject("inj_busy", 3, 7, 35, 10, 7);
      rw(3, 1'b0, 7, '0);
      tick();
      check("inj_busy_word", {25'd0, bus.dccm_bank_ecc[27:21], bus.dccm_bank_dout[127:96]},
            {25'd0, 7'h08, 32'h0000_0000});

      // Out-of-range bit index is rejected immediately.
      inject("inj_bit39", 0, 2, 39, 0, 0);

      // Two flips of the same bit restore the word.
      saved = model[0][9];
      inject("inj_dbl_a", 0, 9, 20, 2, 1);
      inject("inj_dbl_b", 0, 9, 20, 0, 0);
      rw(0, 1'b0, 9, '0);
      tick();
      check("inj_dbl_word", {25'd0, bus.dccm_bank_ecc[6:0], bus.dccm_bank_dout[31:0]}, {25'd0, saved});

      // Randomised traffic with occasional injections.
      for (int i = 0; i < 300; i++) begin
         if (i % 30 == 15) begin
            inject("inj_rand", $urandom_range(0, NB-1), $urandom_range(0, 15),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(39, 63) : $urandom_range(0, 38),
                   $urandom_range(0, 5), $urandom_range(0, 15));
         end
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 2) != 0) begin
               rw(b, 1'($urandom), $urandom_range(0, 15), 39'({$urandom, $urandom}));
            end
         end
         tick();
      end

      // ---- small instance: timeout leaves the array untouched ----
      bus2.dccm_clken        = 2'b10;
      bus2.dccm_wren_bank    = 2'b10;
      bus2.dccm_addr_bank    = 8'h30;
      bus2.dccm_wr_data_bank = {32'hCAFE_F00D, 32'h0};
      bus2.dccm_wr_ecc_bank  = {7'h2A, 7'h00};
      tick();
      bus2.dccm_addr_bank = 8'h00;  // bank 1 stays busy with writes to word 0
      bus2.inj_req  = 1'b1;
      bus2.inj_bank = 2'd1;
      bus2.inj_addr = 4'd3;
      bus2.inj_bit  = 6'd7;
      got_edge = -1;
      got_err  = 1'b0;
      for (int t = 0; t < 40 && got_edge < 0; t++) begin
         tick();
         if (bus2.inj_ack) begin
            got_edge = t;
            got_err  = bus2.inj_err;
         end
      end
      bus2.inj_req = 1'b0;
      check("tmo_ack_cycle", 64'(got_edge), 64'(S_TMO + 1));
      check("tmo_err", {63'd0, got_err}, 64'd1);
      s_idle();
      tick();
      bus2.dccm_clken     = 2'b10;
      bus2.dccm_addr_bank = 8'h30;
      tick();
      s_idle();
      check("tmo_word", {25'd0, bus2.dccm_bank_ecc[13:7], bus2.dccm_bank_dout[63:32]},
            {25'd0, 7'h2A, 32'hCAFE_F00D});

      // ---- small instance: bank 3 does not exist with two banks ----
      bus2.inj_req  = 1'b1;
      bus2.inj_bank = 2'd3;
      bus2.inj_bit  = 6'd0;
      tick();
      bus2.inj_req = 1'b0;
      check("badbank_ack", {62'd0, bus2.inj_ack, bus2.inj_err}, 64'd3);
      tick();
      check("badbank_pulse", {63'd0, bus2.inj_ack}, 64'd0);

      // ---- small instance: reset during WAIT ----
      bus2.dccm_clken     = 2'b01;
      bus2.dccm_wren_bank = 2'b01;
      bus2.inj_req  = 1'b1;
      bus2.inj_bank = 2'd0;
      bus2.inj_addr = 4'd1;
      bus2.inj_bit  = 6'd0;
      tick();
      tick();
      tick();
      check("rstw_noack_pre", {63'd0, bus2.inj_ack}, 64'd0);
      rst2_l = 1'b0;
      #1;
      check("rstw_ack", {62'd0, bus2.inj_ack, bus2.inj_err}, 64'd0);
      check("rstw_dout", 64'(bus2.dccm_bank_dout), 64'd0);
      check("rstw_ecc", 64'(bus2.dccm_bank_ecc), 64'd0);
      bus2.inj_req = 1'b0;
      s_idle();
      tick();
      rst2_l = 1'b1;
      tick();
      check("rstw_noack_post", {63'd0, bus2.inj_ack}, 64'd0);
      // Back in IDLE: a bad request is answered after its own clock.
      bus2.inj_req  = 1'b1;
      bus2.inj_bank = 2'd2;
      tick();
      bus2.inj_req = 1'b0;
      check("rstw_idle_ack", {62'd0, bus2.inj_ack, bus2.inj_err}, 64'd3);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
